data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares the single-port 16x10 data memory between two requesters: the pipeline MEM stage (cpu) and a loader/debug DMA port (dma).
- Picks one winner per cycle and drives the memory's address, write data, write enable and read enable from that winner.
- Returns read data one cycle later through a registered response, and asserts a stall to the pipeline when the cpu loses arbitration.

Parameters:
- ADDR_W, 4, memory address width (16 words)
- DATA_W, 10, memory data width
- STARVE_LIMIT, 3, consecutive lost dma cycles before dma is forced to win the next contention (range 1..7)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  cpu access request, held until granted
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  cpu word address
- cpu_wdata  in  DATA_W  cpu write data
- cpu_gnt  out  1  cpu owns the memory this cycle
- cpu_rdata  out  DATA_W  registered cpu read data
- cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
- cpu_stall  out  1  cpu_req and not cpu_gnt
- dma_req, dma_we, dma_addr, dma_wdata  in  1/1/ADDR_W/DATA_W  same meaning for dma
- dma_gnt, dma_rdata, dma_rvalid  out  1/DATA_W/1  same meaning for dma
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_we  out  1  to memory write enable
- mem_re  out  1  to memory read enable
- mem_rdata  in  DATA_W  from memory, combinational read

Behaviour:
- Reset: all gnt, rvalid, stall and mem_* outputs are 0. rdata registers, starve counter and last-winner pointer are 0. owner = IDLE.
- Grants are combinational within the cycle. Only one gnt may be high at a time. A grant lasts one cycle per access.
- Memory drive:
  - Winner's addr/wdata go to mem_addr/mem_wdata.
  - mem_we = winner's we. mem_re = not winner's we.
  - With no winner, mem_* = 0 and mem_re = 0.
- Arbitration (default, fixed priority):
  - Only one requester: it wins.
  - Both requesting: cpu wins, unless starve_cnt == STARVE_LIMIT, in which case dma wins.
- starve_cnt (3-bit):
  - Increments when dma_req is high and dma loses.
  - Clears when dma wins or dma_req is low.
  - Saturates at STARVE_LIMIT.
- owner register (states IDLE / CPU / DMA): next state = winner of the current cycle, or IDLE if none. Used only to route the registered response.
- Response latency:
  - On a granted read, mem_rdata is captured at the granting edge.
  - Next cycle: the matching rvalid = 1 and rdata holds the captured value.
  - rdata holds its value until the next read. rvalid stays 0 for writes.
- Back-to-back: a requester may be granted on consecutive cycles. A response and a new grant may coincide.
- Both requesters writing the same address in the same cycle: only the winner's write reaches memory. The loser stays stalled and writes in a later cycle.
- cpu_stall = cpu_req and not cpu_gnt (combinational).
- Reset asserted mid-access: a pending rvalid is dropped at the next edge, the counter clears, and owner returns to IDLE.
- A request with X on addr while req = 0 must not propagate to mem_*, which stays forced to 0.

Optional Feature:
- Macro: DMARB_ROUND_ROBIN_EN.
- Defined: contention is resolved by a 1-bit last-winner pointer; the requester that did not win last time wins. The pointer updates only on contention. starve_cnt is held at 0 and STARVE_LIMIT is ignored.
- Undefined: fixed cpu priority with starvation override, as above.

Decomposition:
- Package dm_arb_pkg holds:
  - ADDR_W and DATA_W constants
  - owner_t enum (IDLE=2'd0, CPU=2'd1, DMA=2'd2)
  - starve counter width constant
- One sub-module, dm_arb_pick: combinational winner selection from the two req bits, starve_cnt and the last-winner pointer; outputs a one-hot grant. The response registers and counters stay in the top module.

Test Plan:
- cpu-only read: after reset, memory word 3 = 10'd11; cpu_req=1, cpu_we=0, cpu_addr=3 for 1 cycle -> cpu_gnt=1 and mem_re=1 that cycle; next cycle cpu_rvalid=1, cpu_rdata=10'd11; cpu_stall stays 0.
- Contention, fixed priority, STARVE_LIMIT=3: cpu_req and dma_req both held high for 8 cycles -> grant pattern C,C,C,D,C,C,C,D; cpu_stall=1 exactly on the D cycles.
- Same-address write collision: cpu writes 10'd5 and dma writes 10'd9 to addr 7 in the same cycle, each held until granted -> cycle 1 mem_we=1, mem_wdata=5; cycle 2 mem_wdata=9; a subsequent read of addr 7 returns 9.
- Reset mid-read: grant a dma read of addr 1, assert reset on the following edge -> dma_rvalid never pulses; all outputs 0; starve_cnt=0.
- With DMARB_ROUND_ROBIN_EN, both requesting for 6 cycles starting from reset pointer = 0 -> grants alternate C,D,C,D,C,D.
- Back-to-back cpu reads of addr 0 then addr 1 (values 10'd10, 10'd15) -> rvalid high for 2 consecutive cycles with rdata 10, then 15.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory arbiter slice.
// The optional DMARB_ROUND_ROBIN_EN build only changes contention resolution.
package dm_arb_pkg;

    localparam int DM_ADDR_W = 4;
    localparam int DM_DATA_W = 10;
    localparam int STARVE_W  = 3;

    // One-hot grant encoding shared by the picker and the top.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_CPU  = 2'b01;
    localparam logic [1:0] GNT_DMA  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        DMA  = 2'd2
    } owner_t;

    function automatic owner_t owner_from_gnt(input logic [1:0] gnt);
        owner_t owner;
        case (gnt)
            GNT_CPU: owner = CPU;
            GNT_DMA: owner = DMA;
            default: owner = IDLE;
        endcase
        return owner;
    endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Combinational winner selection for the data-memory arbiter.
// Macro DMARB_ROUND_ROBIN_EN: contention follows the last-winner pointer instead of cpu priority.
module dm_arb_pick
    import dm_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 3
) (
    input  logic                cpu_req,
    input  logic                dma_req,
    input  logic [STARVE_W-1:0] starve_cnt,
    input  logic                last_win,
    output logic [1:0]          gnt
);

    localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

    // last_win = 1 means cpu took the previous contention, so dma is owed the next one.
`ifdef DMARB_ROUND_ROBIN_EN
    logic unused_s;
    assign unused_s = ^{starve_cnt, LIMIT_C};
`else
    logic unused_s;
    assign unused_s = last_win;
`endif

    // Resolve the winner for this cycle
    always_comb begin
        gnt = GNT_NONE;
        if (cpu_req && dma_req) begin
`ifdef DMARB_ROUND_ROBIN_EN
            if (last_win) begin
                gnt = GNT_DMA;
            end else begin
                gnt = GNT_CPU;
            end
`else
            if (starve_cnt == LIMIT_C) begin
                gnt = GNT_DMA;
            end else begin
                gnt = GNT_CPU;
            end
`endif
        end else if (cpu_req) begin
            gnt = GNT_CPU;
        end else if (dma_req) begin
            gnt = GNT_DMA;
        end else begin
            gnt = GNT_NONE;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester (cpu / dma) arbiter for the single-port 16x10 data memory with registered read responses.
// Macro DMARB_ROUND_ROBIN_EN selects round-robin contention; undefined gives cpu priority with dma starvation override.
module data_mem_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W       = DM_ADDR_W,
    parameter int DATA_W       = DM_DATA_W,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic                cpu_req_s;
    logic                dma_req_s;
    logic                contention_s;
    logic [1:0]          gnt_s;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                last_q, last_d;
    owner_t              owner_q, owner_d;
    logic                rd_q, rd_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;

    // Requests are ignored while reset is held so nothing reaches the memory.
    assign cpu_req_s    = cpu_req & ~reset;
    assign dma_req_s    = dma_req & ~reset;
    assign contention_s = cpu_req_s & dma_req_s;

    dm_arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .cpu_req    (cpu_req_s),
        .dma_req    (dma_req_s),
        .starve_cnt (starve_q),
        .last_win   (last_q),
        .gnt        (gnt_s)
    );

    assign cpu_gnt   = gnt_s[0];
    assign dma_gnt   = gnt_s[1];
    assign cpu_stall = cpu_req_s & ~gnt_s[0];

    // Route the winner onto the memory port; no winner forces everything to zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (gnt_s)
            GNT_CPU: begin
                mem_addr  = cpu_addr;
                mem_wdata = cpu_wdata;
                mem_we    = cpu_we;
                mem_re    = ~cpu_we;
            end
            GNT_DMA: begin
                mem_addr  = dma_addr;
                mem_wdata = dma_wdata;
                mem_we    = dma_we;
                mem_re    = ~dma_we;
            end
            default: begin
                mem_addr  = '0;
                mem_wdata = '0;
                mem_we    = 1'b0;
                mem_re    = 1'b0;
            end
        endcase
    end

    // Next-state for owner, response capture, pointer and starvation counter
    always_comb begin
        owner_d     = owner_from_gnt(gnt_s);
        rd_d        = (gnt_s[0] & ~cpu_we) | (gnt_s[1] & ~dma_we);
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
        last_d      = last_q;
        starve_d    = '0;

        if (gnt_s[0] && !cpu_we) begin
            cpu_rdata_d = mem_rdata;
        end else begin
            cpu_rdata_d = cpu_rdata_q;
        end

        if (gnt_s[1] && !dma_we) begin
            dma_rdata_d = mem_rdata;
        end else begin
            dma_rdata_d = dma_rdata_q;
        end

        if (contention_s) begin
            last_d = gnt_s[0];
        end else begin
            last_d = last_q;
        end

`ifdef DMARB_ROUND_ROBIN_EN
        starve_d = '0;
`else
        // Count consecutive lost dma cycles, saturating at the override threshold.
        if (dma_req_s && !gnt_s[1]) begin
            if (starve_q == STARVE_W'(STARVE_LIMIT)) begin
                starve_d = starve_q;
            end else begin
                starve_d = starve_q + 3'd1;
            end
        end else begin
            starve_d = '0;
        end
`endif
    end

    // State and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q     <= IDLE;
            rd_q        <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            last_q      <= 1'b0;
            starve_q    <= '0;
        end else begin
            owner_q     <= owner_d;
            rd_q        <= rd_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
            last_q      <= last_d;
            starve_q    <= starve_d;
        end
    end

    assign cpu_rvalid = rd_q & (owner_q == CPU);
    assign dma_rvalid = rd_q & (owner_q == DMA);
    assign cpu_rdata  = cpu_rdata_q;
    assign dma_rdata  = dma_rdata_q;

endmodule
